// File: rtl/core_pkg.sv
// Shared core definitions: EX Branch-code encoding and its taken/not-taken decode.
package core_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  // Resolved direction for a Branch code; 011 and BR_NONE are never taken.
  function automatic logic br_taken(logic [2:0] br, logic zero, logic lt);
    logic t;
    t = 1'b0;
    unique case (br)
      BR_JAL:  t = 1'b1;
      BR_JALR: t = 1'b1;
      BR_BEQ:  t = zero;
      BR_BNE:  t = !zero;
      BR_BLT:  t = lt;
      BR_BGE:  t = !lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack with a circular top pointer; pushes past full overwrite the oldest entry.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [XLEN-1:0]              data_i,
  output logic [XLEN-1:0]              top_o,
  output logic [$clog2(RAS_DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_idx;
  logic            wr_en;
  logic            do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // Pop+push in one cycle rewrites the current top in place.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (do_pop && push_i) begin
      wr_en = 1'b1;
    end else if (do_pop) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end else if (push_i) begin
      ptr_d  = ptr_q + PW'(1);
      wr_idx = ptr_q + PW'(1);
      wr_en  = 1'b1;
      if (count_q != CW'(RAS_DEPTH)) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (wr_en) mem_q[wr_idx] <= data_i;
    end
  end

  assign top_o   = mem_q[ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: JAL/RAS prediction at fetch, branch/jump resolution in EX, flush-driven redirect.
module pc_gen_ras
  import core_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     RAS_EN    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        if_jal_hint,
  input  logic                        if_call_hint,
  input  logic                        if_ret_hint,
  input  logic [XLEN-1:0]             if_imm,
  input  logic                        ex_valid,
  input  logic [2:0]                  ex_branch,
  input  logic                        ex_zero,
  input  logic                        ex_result0,
  input  logic [XLEN-1:0]             ex_imm,
  input  logic [XLEN-1:0]             ex_busa,
  input  logic [XLEN-1:0]             ex_pc,
  input  logic                        ex_pred_taken,
  input  logic [XLEN-1:0]             ex_pred_target,
  output logic [XLEN-1:0]             pc,
  output logic                        pred_taken,
  output logic [XLEN-1:0]             pred_target,
  output logic                        flush,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  localparam logic RAS_ON = (RAS_EN != 0);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ras_top;
  logic            ras_push, ras_pop, ras_hit, upd;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target, ex_correct;

  // EX resolution of the instruction carried down with its prediction.
  always_comb begin
    ex_taken   = br_taken(ex_branch, ex_zero, ex_result0);
    ex_target  = (ex_branch == BR_JALR) ? ((ex_busa + ex_imm) & ~XLEN'(1))
                                        : (ex_pc + ex_imm);
    ex_correct = ex_taken ? ex_target : (ex_pc + XLEN'(4));
    flush      = !rst && ex_valid &&
                 ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  end

  // Fetch prediction; a ret with an empty stack falls through to JAL/sequential.
  always_comb begin
    ras_hit     = RAS_ON && if_ret_hint && (ras_count != '0);
    pred_taken  = 1'b0;
    pred_target = pc_q + XLEN'(4);
    if (ras_hit) begin
      pred_taken  = 1'b1;
      pred_target = ras_top;
    end else if (if_jal_hint) begin
      pred_taken  = 1'b1;
      pred_target = pc_q + if_imm;
    end
  end

  // Stack moves only on cycles where fetch actually advances down the predicted path.
  assign upd      = !rst && !flush && !stall;
  assign ras_push = RAS_ON && upd && if_call_hint;
  assign ras_pop  = RAS_ON && upd && if_ret_hint;

  always_comb begin
    pc_d = pred_target;
    if (flush)      pc_d = ex_correct;
    else if (stall) pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_q + XLEN'(4)),
    .top_o   (ras_top),
    .count_o (ras_count)
  );

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: expectations queued with stimulus, popped when outputs settle.
module tb_pc_gen_ras;
  import core_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAS_DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, stall, if_jal_hint, if_call_hint, if_ret_hint;
  logic [XLEN-1:0] if_imm, ex_imm, ex_busa, ex_pc, ex_pred_target;
  logic            ex_valid, ex_zero, ex_result0, ex_pred_taken;
  logic [2:0]      ex_branch;
  logic [XLEN-1:0] pc, pred_target;
  logic            pred_taken, flush;
  logic [$clog2(RAS_DEPTH):0] ras_count;

  typedef struct { string name; logic [31:0] val; } exp_t;
  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] act;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  pc_gen_ras #(.XLEN(XLEN), .RESET_PC(32'h0), .RAS_DEPTH(RAS_DEPTH), .RAS_EN(1)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .if_jal_hint(if_jal_hint), .if_call_hint(if_call_hint), .if_ret_hint(if_ret_hint), .if_imm(if_imm),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_result0(ex_result0),
    .ex_imm(ex_imm), .ex_busa(ex_busa), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush), .ras_count(ras_count)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; if_jal_hint = 0; if_call_hint = 0; if_ret_hint = 0; if_imm = '0;
    ex_valid = 0; ex_branch = BR_NONE; ex_zero = 0; ex_result0 = 0; ex_imm = '0;
    ex_busa = '0; ex_pc = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic sb_push(input string n, input logic [31:0] v);
    sb_q.push_back('{n, v});
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    ex_valid = 1; ex_branch = BR_JAL; ex_imm = 32'h40;   // would mispredict if not in reset
    step(); step();
    sb_push("rst_pc", 32'h0); sb_push("rst_cnt", 32'h0); sb_push("rst_flush", 32'h0);
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    e = sb_q.pop_front(); act = 32'(ras_count); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    e = sb_q.pop_front(); act = 32'(flush); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    clear_inputs(); rst = 0;
    for (int i = 1; i <= 3; i++) sb_push("idle_pc", 32'(4 * i));
    for (int i = 0; i < 3; i++) begin
      step();
      e = sb_q.pop_front(); act = pc; n_chk++;
      if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    end
    stall = 1;
    sb_push("stall_pc", 32'hC); sb_push("stall_pc", 32'hC);
    for (int i = 0; i < 2; i++) begin
      step();
      e = sb_q.pop_front(); act = pc; n_chk++;
      if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    end
    stall = 0;
  endtask

  task automatic test_jal();
    step();
    sb_push("jal_pc_in", 32'h10);
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    if_jal_hint = 1; if_imm = 32'h40; settle();
    sb_push("jal_pred_tgt", 32'h50); sb_push("jal_pred_tk", 32'h1);
    e = sb_q.pop_front(); act = pred_target; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    e = sb_q.pop_front(); act = 32'(pred_taken); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    sb_push("jal_pc", 32'h50);
    step();
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    clear_inputs();
    ex_valid = 1; ex_branch = BR_JAL; ex_pc = 32'h10; ex_imm = 32'h40;
    ex_pred_taken = 1; ex_pred_target = 32'h50; settle();
    sb_push("jal_ex_flush", 32'h0);
    e = sb_q.pop_front(); act = 32'(flush); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    sb_push("jal_seq_pc", 32'h54);
    step();
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_branch_flush();
    for (int s = 0; s < 2; s++) begin
      ex_valid = 1; ex_branch = BR_BEQ; ex_pc = 32'h20; ex_imm = 32'h100; ex_zero = 1;
      ex_pred_taken = 0; stall = (s == 1); settle();
      sb_push(s == 0 ? "beq_flush" : "beq_flush_stall", 32'h1);
      e = sb_q.pop_front(); act = 32'(flush); n_chk++;
      if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
      sb_push(s == 0 ? "beq_pc" : "beq_pc_stall", 32'h120);
      step();
      e = sb_q.pop_front(); act = pc; n_chk++;
      if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    end
    clear_inputs();
    ex_valid = 1; ex_branch = BR_BNE; ex_pc = 32'h20; ex_imm = 32'h100; ex_zero = 1; settle();
    sb_push("bne_nt_flush", 32'h0);
    e = sb_q.pop_front(); act = 32'(flush); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    sb_push("bne_nt_pc", 32'h124);
    step();
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_call_ret();
    ex_valid = 1; ex_branch = BR_JAL; ex_pc = 32'h0; ex_imm = 32'h30;   // redirect fetch to 0x30
    step(); clear_inputs();
    if_call_hint = 1; if_jal_hint = 1; if_imm = 32'h50; settle();
    sb_push("call_pred_tgt", 32'h80);
    e = sb_q.pop_front(); act = pred_target; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    step();
    sb_push("call_pc", 32'h80); sb_push("call_cnt", 32'h1);
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    e = sb_q.pop_front(); act = 32'(ras_count); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    clear_inputs();
    if_ret_hint = 1; settle();
    sb_push("ret_pred_tgt", 32'h34);
    e = sb_q.pop_front(); act = pred_target; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    step();
    sb_push("ret_pc", 32'h34); sb_push("ret_cnt", 32'h0);
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    e = sb_q.pop_front(); act = 32'(ras_count); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] model[$];
    for (int i = 0; i < 5; i++) begin
      if_call_hint = 1;
      model.push_back(pc + 32'd4);
      if (model.size() > RAS_DEPTH) void'(model.pop_front());
      step();
    end
    clear_inputs();
    sb_push("ovf_cnt", 32'(RAS_DEPTH));
    e = sb_q.pop_front(); act = 32'(ras_count); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if_ret_hint = 1; settle();
      sb_push("ovf_ret_tgt", model.pop_back());
      e = sb_q.pop_front(); act = pred_target; n_chk++;
      if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
      step();
    end
    settle();
    sb_push("empty_ret_tk", 32'h0); sb_push("empty_ret_tgt", pc + 32'd4);
    e = sb_q.pop_front(); act = 32'(pred_taken); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    e = sb_q.pop_front(); act = pred_target; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    step();
    sb_push("empty_ret_cnt", 32'h0);
    e = sb_q.pop_front(); act = 32'(ras_count); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_call_ret_same();
    if_call_hint = 1; step();                    // push pc+4 = 0x44
    if_ret_hint = 1; settle();                   // jalr x1,x1 at 0x44
    sb_push("cr_pred_tgt", 32'h44);
    e = sb_q.pop_front(); act = pred_target; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    step();
    sb_push("cr_cnt", 32'h1);
    e = sb_q.pop_front(); act = 32'(ras_count); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    if_call_hint = 0; settle();
    sb_push("cr_new_top", 32'h48);
    e = sb_q.pop_front(); act = pred_target; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    step(); clear_inputs();
  endtask

  task automatic test_jalr_rst();
    ex_valid = 1; ex_branch = BR_JALR; ex_pc = 32'h48; ex_busa = 32'hFFFF_FFFF; ex_imm = 32'h3;
    ex_pred_taken = 1; ex_pred_target = 32'h2; settle();
    sb_push("jalr_wrap_flush", 32'h0);
    e = sb_q.pop_front(); act = 32'(flush); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    ex_busa = 32'h1001; ex_imm = 32'h2; ex_pred_target = 32'h2000; settle();
    sb_push("jalr_flush", 32'h1);
    e = sb_q.pop_front(); act = 32'(flush); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    step();
    sb_push("jalr_pc", 32'h1002);
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    rst = 1; stall = 1; if_call_hint = 1; settle();
    sb_push("rst_over_flush", 32'h0);
    e = sb_q.pop_front(); act = 32'(flush); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    step();
    sb_push("rst_over_pc", 32'h0); sb_push("rst_over_cnt", 32'h0);
    e = sb_q.pop_front(); act = pc; n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    e = sb_q.pop_front(); act = 32'(ras_count); n_chk++;
    if (act !== e.val) $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val); else n_pass++;
    rst = 0; clear_inputs();
  endtask

  initial begin
    test_reset();
    test_jal();
    test_branch_flush();
    test_call_ret();
    test_ras_overflow();
    test_call_ret_same();
    test_jalr_rst();
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
